rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage. It is the sequential successor to the combinational MUX32_Nx1 tree.
- Channels present data with valid/ready handshakes.
- The block selects one channel per cycle, either round-robin or by forced select, and registers the winner.
- Sits between multiple requesters (register-file read ports, memory clients) and a single shared consumer in the datapath.

Parameters:
DATA_WIDTH, 32, bit width of each channel and of the output
NUM_CH, 4, number of input channels (2..32; need not be a power of two)
SEL_WIDTH, 2, width of select/pointer fields; must be at least clog2(NUM_CH)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
IN_DATA  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
IN_VALID  input  NUM_CH  channel i has data
IN_READY  output  NUM_CH  channel i is accepted this cycle (combinational)
MODE  input  1  0 = round-robin, 1 = forced select
FORCE_SEL  input  SEL_WIDTH  channel index used when MODE=1
OUT_DATA  output  DATA_WIDTH  registered selected data
OUT_SEL  output  SEL_WIDTH  index of the channel that produced OUT_DATA
OUT_VALID  output  1  OUT_DATA/OUT_SEL valid
OUT_READY  input  1  consumer accepts output

Behaviour:
- Reset:
  - Asynchronous on RST low: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, internal pointer PTR=0.
  - While RST is low, IN_READY=0.
  - Data held in the output register is discarded, not delivered.
  - Release is synchronous to CLK; the first grant is possible in the first cycle after release.
- Load enable: LOAD = !OUT_VALID || OUT_READY. The output register can accept new data whenever it is empty or is being drained in the same cycle.
- Grant, combinational, at most one channel per cycle:
  - MODE=0: first i with IN_VALID[i]=1, scanning PTR, PTR+1, ..., NUM_CH-1, 0, ..., PTR-1.
  - MODE=1: grant = FORCE_SEL if FORCE_SEL < NUM_CH and IN_VALID[FORCE_SEL]=1, else no grant. FORCE_SEL >= NUM_CH never grants and is not an error.
- IN_READY[i] = LOAD && grant==i. IN_READY is never asserted for a channel with IN_VALID=0.
- Transfer on channel g occurs when IN_VALID[g] && IN_READY[g]. At the next CLK edge: OUT_DATA <= channel g data, OUT_SEL <= g, OUT_VALID <= 1.
- If LOAD=1 and there is no grant: OUT_VALID <= 0. OUT_DATA and OUT_SEL hold their last values.
- If LOAD=0 (OUT_VALID=1, OUT_READY=0): OUT_DATA, OUT_SEL and OUT_VALID are held stable, and all IN_READY=0.
- Latency and throughput: one cycle from input transfer to OUT_VALID. Full throughput is one transfer per cycle under continuous OUT_READY=1.
- PTR update on every transfer in either mode: PTR <= (g == NUM_CH-1) ? 0 : g+1. There is no update without a transfer. MODE may change on any cycle; the new MODE takes effect in the same cycle.
- Fairness: in MODE=0 with all channels continuously valid, each channel is granted exactly once per NUM_CH transfers.
- Simultaneous drain and load: when OUT_READY=1 and OUT_VALID=1 with a grant, the old word is consumed and the new word loaded on the same edge. There is no bubble.

Decomposition:
- Shared package: MODE_RR=0 and MODE_FORCE=1 constants; default DATA_WIDTH=32 (matches the 32-bit datapath); the channel-slice indexing macro.
- Sub-module rr_pick (combinational):
  - Inputs: request vector, PTR, MODE, FORCE_SEL.
  - Outputs: grant_valid and grant index.
  - Implemented as a rotate, then fixed priority, then un-rotate.
- The top level holds PTR, the output register and the handshake logic.

Test Plan:
1. Reset: drive RST=0 mid-stream with OUT_VALID=1 → OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, IN_READY=0 immediately, without waiting for CLK. After release, the first grant goes to ch0.
2. Round-robin saturation: NUM_CH=4, all IN_VALID=1, IN_DATA ch i = 0x1000_000i, OUT_READY=1 → OUT_DATA sequence 0x10000000, 0x10000001, 0x10000002, 0x10000003, 0x10000000, one per cycle, OUT_SEL 0,1,2,3,0.
3. Backpressure: OUT_READY=0 for 3 cycles while OUT_VALID=1 with OUT_SEL=1 → OUT_DATA/OUT_SEL held and IN_READY=4'b0000. On OUT_READY=1, the next word is from ch2 on the following cycle.
4. Sparse and wrap-around: with PTR=0, only ch3 valid → ch3 granted and PTR becomes 0. Next cycle ch0 and ch1 valid → ch0 granted, then ch1.
5. Forced mode: MODE=1, FORCE_SEL=2, all valid → only IN_READY[2] asserted, OUT_SEL=2 repeatedly. FORCE_SEL=2 with ch2 invalid → no grant, OUT_VALID drops to 0.
6. Out-of-range select and non-power-of-two: NUM_CH=3, SEL_WIDTH=2, MODE=1, FORCE_SEL=3 → no grant. MODE=0, all valid → order 0,1,2,0; PTR never reaches 3.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: mode constants, default width and channel-slice macro
// shared by the arbitrated mux and its picker.
`define RR_CH(idx, w) (idx) * (w) +: (w)

package rr_arb_mux_pkg;
    localparam logic MODE_RR            = 1'b0;
    localparam logic MODE_FORCE         = 1'b1;
    localparam int   DEFAULT_DATA_WIDTH = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational grant selection, round-robin from a pointer
// (rotate, fixed priority, un-rotate) or forced channel index.
module rr_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM_CH-1:0]    i_req,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    input  logic                 i_mode,
    input  logic [SEL_WIDTH-1:0] i_force_sel,
    output logic                 o_gnt_valid,
    output logic [SEL_WIDTH-1:0] o_gnt
);
    logic [2*NUM_CH-1:0]  w_dbl;
    logic [NUM_CH-1:0]    w_rot;
    logic                 w_rr_valid;
    logic [SEL_WIDTH-1:0] w_rr_idx;
    logic [SEL_WIDTH:0]   w_sum;
    logic [SEL_WIDTH-1:0] w_rr_gnt;
    logic                 w_force_ok;

    // pointer is always < NUM_CH, so the window stays inside the doubled vector
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: NUM_CH];

    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (w_rot[k]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = SEL_WIDTH'(k);
            end
    end

    assign w_sum    = {1'b0, i_ptr} + {1'b0, w_rr_idx};
    assign w_rr_gnt = (w_sum >= (SEL_WIDTH+1)'(NUM_CH)) ?
                      SEL_WIDTH'(w_sum - (SEL_WIDTH+1)'(NUM_CH)) : w_sum[SEL_WIDTH-1:0];

    // a select at or beyond NUM_CH shifts the mask out entirely and never grants
    assign w_force_ok  = |(i_req & (NUM_CH'(1) << i_force_sel));
    assign o_gnt_valid = (i_mode == MODE_FORCE) ? w_force_ok : w_rr_valid;
    assign o_gnt       = (i_mode == MODE_FORCE) ? i_force_sel : w_rr_gnt;
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbitrated multiplexer with a registered
// output stage; round-robin or forced channel selection.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA,
    input  logic [NUM_CH-1:0]            IN_VALID,
    output logic [NUM_CH-1:0]            IN_READY,
    input  logic                         MODE,
    input  logic [SEL_WIDTH-1:0]         FORCE_SEL,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic [SEL_WIDTH-1:0]         OUT_SEL,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY
);
    logic [SEL_WIDTH-1:0]  r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_valid;
    logic                  w_load;
    logic                  w_gv;
    logic [SEL_WIDTH-1:0]  w_g;
    logic                  w_xfer;

    rr_pick #(.NUM_CH(NUM_CH), .SEL_WIDTH(SEL_WIDTH)) u_pick (
        .i_req       (IN_VALID),
        .i_ptr       (r_ptr),
        .i_mode      (MODE),
        .i_force_sel (FORCE_SEL),
        .o_gnt_valid (w_gv),
        .o_gnt       (w_g)
    );

    assign w_load    = !r_valid || OUT_READY;
    // RST gates ready so nothing is accepted while the block is held in reset
    assign w_xfer    = RST && w_load && w_gv;
    assign IN_READY  = w_xfer ? NUM_CH'(1) << w_g : '0;
    assign OUT_DATA  = r_data;
    assign OUT_SEL   = r_sel;
    assign OUT_VALID = r_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= w_gv;
            if (w_gv) begin
                r_data <= IN_DATA[`RR_CH(w_g, DATA_WIDTH)];
                r_sel  <= w_g;
                r_ptr  <= (w_g == SEL_WIDTH'(NUM_CH - 1)) ? '0 : w_g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: table-driven and randomized checks of a 4-channel and a
// 3-channel instance against a scan-order reference model.
module tb_rr_arb_mux;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_valid = '0;
    logic         mode = 1'b0;
    logic [1:0]   fsel = '0;
    logic         out_ready = 1'b1;
    logic [3:0]   rdy4;
    logic [31:0]  od4;
    logic [1:0]   os4;
    logic         ov4;
    logic [2:0]   rdy3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    logic         ov3;

    int tests = 0;
    int fails = 0;

    int          m_ptr[2];
    int          m_sel[2];
    logic        m_valid[2];
    logic [31:0] m_data[2];

    typedef struct {
        logic [3:0] v;
        logic       m;
        logic [1:0] f;
        logic       r;
        logic       ov4;
        logic [1:0] s4;
        logic       ov3;
        logic [1:0] s3;
    } vec_t;

    vec_t tbl[23];

    always #5 clk = ~clk;

    rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) u_dut4 (
        .CLK(clk), .RST(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy4),
        .MODE(mode), .FORCE_SEL(fsel), .OUT_DATA(od4), .OUT_SEL(os4), .OUT_VALID(ov4),
        .OUT_READY(out_ready)
    );

    rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(3), .SEL_WIDTH(2)) u_dut3 (
        .CLK(clk), .RST(rst_n), .IN_DATA(in_data[95:0]), .IN_VALID(in_valid[2:0]), .IN_READY(rdy3),
        .MODE(mode), .FORCE_SEL(fsel), .OUT_DATA(od3), .OUT_SEL(os3), .OUT_VALID(ov3),
        .OUT_READY(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // first valid channel in scan order ptr, ptr+1, ... modulo n; -1 when none
    function automatic int rr_grant(int n, int ptr, logic [3:0] v, logic m, int f);
        if (m) return (f < n && v[f]) ? f : -1;
        for (int j = 0; j < n; j++)
            if (v[(ptr + j) % n]) return (ptr + j) % n;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_sel[d] = 0; m_valid[d] = 1'b0; m_data[d] = '0;
        end
    endfunction

    task automatic tick(input string tag);
        int n;
        int g;
        logic ld;
        logic [3:0] er;
        #1;
        for (int d = 0; d < 2; d++) begin
            n  = (d == 1) ? 3 : 4;
            g  = rr_grant(n, m_ptr[d], in_valid, mode, int'(fsel));
            ld = !m_valid[d] || out_ready;
            er = '0;
            if (rst_n && ld && g >= 0) er[g] = 1'b1;
            chk($sformatf("%s n%0d out_valid", tag, n), 32'(d == 1 ? ov3 : ov4), 32'(m_valid[d]));
            chk($sformatf("%s n%0d out_sel", tag, n), 32'(d == 1 ? os3 : os4), 32'(m_sel[d]));
            chk($sformatf("%s n%0d out_data", tag, n), d == 1 ? od3 : od4, m_data[d]);
            chk($sformatf("%s n%0d in_ready", tag, n), 32'(d == 1 ? {1'b0, rdy3} : rdy4), 32'(er));
            if (rst_n && ld) begin
                m_valid[d] = (g >= 0);
                if (g >= 0) begin
                    m_data[d] = in_data[g*32 +: 32];
                    m_sel[d]  = g;
                    m_ptr[d]  = (g + 1) % n;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1},
            '{4'h8, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0, 2'd1},
            '{4'h3, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0},
            '{4'h3, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1},
            '{4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1},
            '{4'hF, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2},
            '{4'hF, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2},
            '{4'hB, 1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0, 2'd2},
            '{4'hF, 1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2},
            '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0}
        };
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            in_valid  = tbl[i].v;
            mode      = tbl[i].m;
            fsel      = tbl[i].f;
            out_ready = tbl[i].r;
            tick($sformatf("row%0d", i));
            chk($sformatf("row%0d n4 ov", i), 32'(ov4), 32'(tbl[i].ov4));
            chk($sformatf("row%0d n4 sel", i), 32'(os4), 32'(tbl[i].s4));
            chk($sformatf("row%0d n4 data", i), od4, 32'h1000_0000 + 32'(tbl[i].s4));
            chk($sformatf("row%0d n3 ov", i), 32'(ov3), 32'(tbl[i].ov3));
            chk($sformatf("row%0d n3 sel", i), 32'(os3), 32'(tbl[i].s3));
        end

        // asynchronous reset while holding a valid word, checked before any edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst ov4", 32'(ov4), 32'h0);
        chk("async_rst od4", od4, 32'h0);
        chk("async_rst os4", 32'(os4), 32'h0);
        chk("async_rst rdy4", 32'(rdy4), 32'h0);
        chk("async_rst rdy3", 32'(rdy3), 32'h0);
        model_reset();
        @(negedge clk);
        tick("rst_hold");
        rst_n = 1'b1;
        tick("rst_release");
        chk("first_grant sel", 32'(os4), 32'h0);
        chk("first_grant ov", 32'(ov4), 32'h1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            fsel      = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
